regfile_debug_port: RTL and testbench

//   Debug/bring-up master for the CPU register file: drives its read and write ports.

---
 rtl/regfile_debug_port.sv | 128 ++++++++++++
 tb/tb_regfile_debug_port.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_debug_port.sv
// Debug/bring-up master for the CPU register file.
// DUMP streams every register out over a valid/ready byte stream, index 0 first.
// LOAD writes bytes taken from an input stream into the registers, index 0 first.
// cpu_halt is held for the whole operation so the core stays off the register file.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for dump_req / load_req (dump wins when both are high)
// DUMP_RD | capture rf_read_data at idx into tx_data, raise tx_valid
// DUMP_TX | hold tx_data/tx_valid until the sink takes the byte
// LOAD    | accept rx bytes, each accepted byte written to register idx
// DONE    | one-cycle done pulse, then back to IDLE
module regfile_debug_port #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int NUM_REGS   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  dump_req,
    input  logic                  load_req,
    output logic                  busy,
    output logic                  cpu_halt,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic [ADDR_WIDTH-1:0] rf_read_addr,
    input  logic [DATA_WIDTH-1:0] rf_read_data,
    output logic [ADDR_WIDTH-1:0] rf_write_addr,
    output logic [DATA_WIDTH-1:0] rf_write_data,
    output logic                  rf_write_en
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DUMP_RD = 3'd1,
        DUMP_TX = 3'd2,
        LOAD    = 3'd3,
        DONE    = 3'd4
    } state_t;

    // idx terminates here; it never wraps because every start reloads it to 0
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REGS - 1);

    state_t                state;
    logic [ADDR_WIDTH-1:0] idx;
    logic                  idx_last;

    assign idx_last = (idx == LAST_IDX);

    // Sequencer: state, index and the registered stream/status outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            idx      <= '0;
            tx_data  <= '0;
            tx_valid <= 1'b0;
            done     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (dump_req) begin
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= DUMP_RD;
                    end else if (load_req) begin
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= LOAD;
                    end
                end
                DUMP_RD: begin
                    tx_data  <= rf_read_data;
                    tx_valid <= 1'b1;
                    state    <= DUMP_TX;
                end
                DUMP_TX: begin
                    if (tx_valid && tx_ready) begin
                        tx_valid <= 1'b0;
                        if (idx_last) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            idx   <= idx + ADDR_WIDTH'(1);
                            state <= DUMP_RD;
                        end
                    end
                end
                LOAD: begin
                    // rx_ready is high throughout LOAD, so rx_valid alone is the handshake
                    if (rx_valid) begin
                        if (idx_last) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            idx <= idx + ADDR_WIDTH'(1);
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    tx_valid <= 1'b0;
                    done     <= 1'b0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    // Load side is combinational so the register file commits on the accepting edge
    assign rx_ready      = (state == LOAD);
    assign rf_write_en   = (state == LOAD) && rx_valid;
    assign rf_write_addr = idx;
    assign rf_write_data = rx_data;
    assign rf_read_addr  = idx;
    assign cpu_halt      = busy;

endmodule

// File: tb/tb_regfile_debug_port.sv
// Bench for regfile_debug_port: directed scenarios plus randomized load/dump rounds,
// checked against an array model of what the register file should contain.
module tb_regfile_debug_port;

    logic       clk = 1'b0;
    logic       reset;
    logic       dump_req, load_req;
    logic       busy, cpu_halt, done;
    logic [7:0] tx_data;
    logic       tx_valid, tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid, rx_ready;
    logic [2:0] rf_read_addr, rf_write_addr;
    logic [7:0] rf_read_data, rf_write_data;
    logic       rf_write_en;

    // second instance: 4-register dump
    logic       dump_req4, load_req4;
    logic       busy4, cpu_halt4, done4;
    logic [7:0] tx_data4;
    logic       tx_valid4, tx_ready4;
    logic [7:0] rx_data4;
    logic       rx_valid4, rx_ready4;
    logic [2:0] rf_read_addr4, rf_write_addr4;
    logic [7:0] rf_read_data4, rf_write_data4;
    logic       rf_write_en4;

    // register file seen by the DUT, with a backdoor for preloading
    logic [7:0] rf_mem [8];
    logic       bd_we;
    logic [2:0] bd_addr;
    logic [7:0] bd_data;

    // expected register contents and load stream bytes
    logic [7:0] model [8];
    logic [7:0] ld [8];

    // monitor results
    logic [7:0] tx_q[$];
    logic [7:0] tx4_q[$];
    int done_cnt = 0, done4_cnt = 0, wen_cnt = 0;
    int stab_err = 0, halt_err = 0, wen_err = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    regfile_debug_port #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .NUM_REGS(8)) dut (
        .clk(clk), .reset(reset), .dump_req(dump_req), .load_req(load_req),
        .busy(busy), .cpu_halt(cpu_halt), .done(done),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .rf_read_addr(rf_read_addr), .rf_read_data(rf_read_data),
        .rf_write_addr(rf_write_addr), .rf_write_data(rf_write_data),
        .rf_write_en(rf_write_en)
    );

    regfile_debug_port #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .NUM_REGS(4)) dut4 (
        .clk(clk), .reset(reset), .dump_req(dump_req4), .load_req(load_req4),
        .busy(busy4), .cpu_halt(cpu_halt4), .done(done4),
        .tx_data(tx_data4), .tx_valid(tx_valid4), .tx_ready(tx_ready4),
        .rx_data(rx_data4), .rx_valid(rx_valid4), .rx_ready(rx_ready4),
        .rf_read_addr(rf_read_addr4), .rf_read_data(rf_read_data4),
        .rf_write_addr(rf_write_addr4), .rf_write_data(rf_write_data4),
        .rf_write_en(rf_write_en4)
    );

    assign rf_read_data  = rf_mem[rf_read_addr];
    assign rf_read_data4 = rf_mem[rf_read_addr4];

    // register file write port (DUT) and preload backdoor
    always @(posedge clk) begin
        if (rf_write_en) rf_mem[rf_write_addr] <= rf_write_data;
        else if (bd_we) rf_mem[bd_addr] <= bd_data;
    end

    // stream, pulse and invariant monitor, sampled away from the active edge
    always @(negedge clk) begin
        if (tx_valid && tx_ready) tx_q.push_back(tx_data);
        if (tx_valid4 && tx_ready4) tx4_q.push_back(tx_data4);
        if (done) done_cnt <= done_cnt + 1;
        if (done4) done4_cnt <= done4_cnt + 1;
        if (rf_write_en) wen_cnt <= wen_cnt + 1;
        if (rf_write_en && !rx_ready) wen_err <= wen_err + 1;
        if (cpu_halt !== busy || cpu_halt4 !== busy4) halt_err <= halt_err + 1;
        if (!reset && prev_stall && (!tx_valid || tx_data !== prev_data)) stab_err <= stab_err + 1;
        prev_stall <= tx_valid && !tx_ready && !reset;
        prev_data  <= tx_data;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input bit rnd);
        for (int i = 0; i < 8; i++) begin
            bd_we   = 1'b1;
            bd_addr = 3'(i);
            bd_data = rnd ? 8'($urandom) : 8'(8'h10 + i);
            model[i] = bd_data;
            tick();
        end
        bd_we = 1'b0;
        tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_halt"}, cpu_halt, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_txv"}, tx_valid, 0);
        chk({tag, "_txd"}, tx_data, 0);
        chk({tag, "_rxr"}, rx_ready, 0);
        chk({tag, "_wen"}, rf_write_en, 0);
        chk({tag, "_addr"}, rf_read_addr, 0);
    endtask

    task automatic check_stream(input string tag, input int base);
        chk({tag, "_len"}, tx_q.size() - base, 8);
        for (int i = 0; i < 8; i++)
            if (base + i < tx_q.size()) chk({tag, "_byte"}, tx_q[base + i], model[i]);
    endtask

    task automatic run_dump(input bit both, input int stall_idx, input int stall_n,
                            input bit rnd_ready, input bit poke_load);
        int stalled = 0;
        int cyc;
        tick();
        dump_req = 1'b1;
        load_req = both;
        tick();
        dump_req = 1'b0;
        load_req = 1'b0;
        chk("dump_busy", busy, 1);
        chk("dump_halt", cpu_halt, 1);
        for (cyc = 0; cyc < 400 && busy; cyc++) begin
            if (tx_valid && stall_n > 0 && int'(rf_read_addr) == stall_idx && stalled < stall_n) begin
                tx_ready = 1'b0;
                chk("stall_data", tx_data, model[stall_idx]);
                chk("stall_valid", tx_valid, 1);
                stalled++;
            end else begin
                tx_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            load_req = poke_load && cyc >= 3 && cyc < 6;
            tick();
        end
        load_req = 1'b0;
        tx_ready = 1'b1;
        chk("dump_end", busy, 0);
        if (stall_n > 0) chk("stall_cycles", stalled, stall_n);
    endtask

    task automatic run_load(input int stop_at, input int pct);
        int k = 0;
        tick();
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
        chk("load_busy", busy, 1);
        chk("load_rxr", rx_ready, 1);
        for (int cyc = 0; cyc < 400 && k < stop_at; cyc++) begin
            rx_valid = ($urandom_range(0, 99) < pct);
            rx_data  = rx_valid ? ld[k] : 8'($urandom);
            @(negedge clk);
            if (rx_valid && rx_ready) begin
                model[k] = ld[k];
                k++;
            end
            tick();
        end
        rx_valid = 1'b0;
        chk("load_count", k, stop_at);
    endtask

    task automatic wait_idle(input string tag);
        for (int c = 0; c < 50 && busy; c++) tick();
        chk(tag, busy, 0);
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 8; i++) chk(tag, rf_mem[i], model[i]);
    endtask

    initial begin
        int base, d0, w0;
        reset = 1'b1;
        dump_req = 0; load_req = 0; tx_ready = 1; rx_valid = 0; rx_data = 0;
        dump_req4 = 0; load_req4 = 0; tx_ready4 = 1; rx_valid4 = 0; rx_data4 = 0;
        bd_we = 0; bd_addr = 0; bd_data = 0;
        repeat (3) tick();
        check_reset_outputs("reset");
        reset = 1'b0;
        tick();

        // 1: full dump of 10..17 with sink always ready
        preload(1'b0);
        base = tx_q.size(); d0 = done_cnt;
        run_dump(1'b0, 0, 0, 1'b0, 1'b0);
        tick();
        check_stream("dump1", base);
        chk("dump1_done", done_cnt - d0, 1);

        // 2: sink stalls 5 cycles on register 3
        base = tx_q.size(); d0 = done_cnt;
        run_dump(1'b0, 3, 5, 1'b0, 1'b0);
        tick();
        check_stream("dump2", base);
        chk("dump2_done", done_cnt - d0, 1);
        chk("stall_data_13", model[3], 8'h13);

        // 3: load A0..A7 with valid gaps
        for (int i = 0; i < 8; i++) ld[i] = 8'(8'hA0 + i);
        d0 = done_cnt; w0 = wen_cnt;
        run_load(8, 55);
        wait_idle("load3_end");
        tick();
        check_regs("load3_reg");
        chk("load3_wen", wen_cnt - w0, 8);
        chk("load3_done", done_cnt - d0, 1);

        // 4: simultaneous requests (dump wins), load_req during dump ignored
        base = tx_q.size(); d0 = done_cnt; w0 = wen_cnt;
        run_dump(1'b1, 0, 0, 1'b0, 1'b1);
        repeat (3) tick();
        check_stream("dump4", base);
        chk("dump4_wen", wen_cnt - w0, 0);
        chk("dump4_done", done_cnt - d0, 1);
        chk("dump4_idle", busy, 0);
        chk("dump4_rxr", rx_ready, 0);

        // 5: reset after 3 load bytes
        for (int i = 0; i < 8; i++) ld[i] = 8'(8'hB0 + i);
        d0 = done_cnt;
        run_load(3, 70);
        reset = 1'b1;
        rx_valid = 1'b1;
        #1;
        check_reset_outputs("rst_load");
        rx_valid = 1'b0;
        tick();
        reset = 1'b0;
        repeat (2) tick();
        chk("rst_load_done", done_cnt - d0, 0);
        check_regs("rst_load_reg");

        // 6: NUM_REGS=4 instance dumps exactly 4 bytes
        base = tx4_q.size(); d0 = done4_cnt;
        tick();
        dump_req4 = 1'b1;
        tick();
        dump_req4 = 1'b0;
        for (int c = 0; c < 100 && busy4; c++) tick();
        tick();
        chk("d4_idle", busy4, 0);
        chk("d4_len", tx4_q.size() - base, 4);
        for (int i = 0; i < 4; i++)
            if (base + i < tx4_q.size()) chk("d4_byte", tx4_q[base + i], model[i]);
        chk("d4_done", done4_cnt - d0, 1);

        // reset during a dump drops tx_valid at once, no done
        d0 = done_cnt;
        tx_ready = 1'b0;
        tick();
        dump_req = 1'b1;
        tick();
        dump_req = 1'b0;
        for (int c = 0; c < 10 && !tx_valid; c++) tick();
        chk("rst_dump_txv_before", tx_valid, 1);
        reset = 1'b1;
        #1;
        chk("rst_dump_txv", tx_valid, 0);
        chk("rst_dump_busy", busy, 0);
        tick();
        reset = 1'b0;
        tx_ready = 1'b1;
        repeat (2) tick();
        chk("rst_dump_done", done_cnt - d0, 0);

        // randomized rounds: random preload, random load, random-ready dump
        for (int r = 0; r < 3; r++) begin
            preload(1'b1);
            for (int i = 0; i < 8; i++) ld[i] = 8'($urandom);
            d0 = done_cnt; w0 = wen_cnt;
            run_load(8, 30 + 20 * r);
            wait_idle("rnd_load_end");
            tick();
            check_regs("rnd_load_reg");
            chk("rnd_load_wen", wen_cnt - w0, 8);
            base = tx_q.size();
            run_dump(1'b0, 0, 0, 1'b1, 1'b0);
            tick();
            check_stream("rnd_dump", base);
            chk("rnd_done", done_cnt - d0, 2);
        end

        chk("inv_halt", halt_err, 0);
        chk("inv_wen", wen_err, 0);
        chk("inv_stable", stab_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
